keycode_router: RTL and testbench

- Multi-slot, multi-player keyboard report router. Sits between the USB keyboard report interface and the per-player movement/action logic.
- Each report strobe is decoded against a per-player key map. The block registers the held-key state and generates press, release and auto-repeat pulses.
- It also tracks each player's most recently pressed direction, so two-key diagonals and re-presses resolve deterministically.

---
 rtl/keycode_pkg.sv | 57 +++++
 rtl/keycode_router_timer.sv | 38 +++
 rtl/keycode_router.sv | 130 +++++++++++++
 tb/tb_keycode_router.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/keycode_pkg.sv
// Shared constants for the keyboard report router: key indices, special
// keycodes, the per-player key map and the last-direction state type.
package keycode_pkg;

   localparam int KEY_UP     = 0;
   localparam int KEY_DOWN   = 1;
   localparam int KEY_LEFT   = 2;
   localparam int KEY_RIGHT  = 3;
   localparam int KEY_ACTION = 4;
   localparam int NUM_DIRS   = 4;

   localparam logic [7:0] KC_ERR_ROLLOVER = 8'h01;
   localparam logic [7:0] KC_NONE         = 8'h00;

   // Per-player last-direction tracker state
   typedef enum logic {
      KS_NONE = 1'b0,
      KS_DIR  = 1'b1
   } key_state_t;

   // Key map: player 0 = W,S,A,D,Space; player 1 = arrows, Enter
   function automatic logic [7:0] map_code(input int player, input int key);
      logic [7:0] code;
      code = KC_NONE;
      if (player == 0) begin
         case (key)
            KEY_UP:     code = 8'h1a;
            KEY_DOWN:   code = 8'h16;
            KEY_LEFT:   code = 8'h04;
            KEY_RIGHT:  code = 8'h07;
            KEY_ACTION: code = 8'h2c;
            default:    code = KC_NONE;
         endcase
      end else if (player == 1) begin
         case (key)
            KEY_UP:     code = 8'h52;
            KEY_DOWN:   code = 8'h51;
            KEY_LEFT:   code = 8'h50;
            KEY_RIGHT:  code = 8'h4f;
            KEY_ACTION: code = 8'h28;
            default:    code = KC_NONE;
         endcase
      end
      return code;
   endfunction

   // Index of the lowest set direction bit; 0 when none is set
   function automatic logic [1:0] lowest_dir(input logic [NUM_DIRS-1:0] dirs);
      logic [1:0] idx;
      idx = 2'd0;
      for (int i = NUM_DIRS - 1; i >= 0; i--) begin
         if (dirs[i]) idx = 2'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/keycode_router_timer.sv
// Auto-repeat timer for a single key: loads the initial delay on press,
// counts down while the key stays held, and emits one-cycle repeat pulses.
module key_repeat_timer #(
   parameter int REPEAT_DELAY  = 24,
   parameter int REPEAT_PERIOD = 8,
   parameter int CW            = 5
) (
   input  logic Clk,
   input  logic Reset,
   input  logic load,
   input  logic clear,
   input  logic held,
   output logic repeat_pulse
);

   logic [CW-1:0] count;

   // Down-counter with terminal-count reload; pulse is registered
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         count        <= '0;
         repeat_pulse <= 1'b0;
      end else begin
         repeat_pulse <= 1'b0;
         if (clear) begin
            count <= '0;
         end else if (load) begin
            count <= CW'(REPEAT_DELAY);
         end else if (held && count == CW'(1)) begin
            repeat_pulse <= 1'b1;
            count        <= CW'(REPEAT_PERIOD);
         end else if (held && count != '0) begin
            count <= count - CW'(1);
         end
      end
   end

endmodule

// File: rtl/keycode_router.sv
// Keyboard report router: decodes each report strobe against the per-player
// key maps, registers held keys, produces press/release/repeat pulses and
// tracks each player's most recent direction.
//
//   state   | meaning
//   KS_NONE | no direction held, last_dir_valid=0, last_dir=0
//   KS_DIR  | last_dir holds the most recent held direction
//
// The release pulse output is named release_pulse because "release" is a
// reserved word in SystemVerilog.
module keycode_router
   import keycode_pkg::*;
#(
   parameter int NUM_SLOTS       = 4,
   parameter int NUM_PLAYERS     = 2,
   parameter int KEYS_PER_PLAYER = 5,
   parameter int REPEAT_DELAY    = 24,
   parameter int REPEAT_PERIOD   = 8
) (
   input  logic                                   Clk,
   input  logic                                   Reset,
   input  logic [8*NUM_SLOTS-1:0]                 keycode,
   input  logic                                   keycode_valid,
   output logic [NUM_PLAYERS*KEYS_PER_PLAYER-1:0] held,
   output logic [NUM_PLAYERS*KEYS_PER_PLAYER-1:0] press,
   output logic [NUM_PLAYERS*KEYS_PER_PLAYER-1:0] release_pulse,
   output logic [NUM_PLAYERS*KEYS_PER_PLAYER-1:0] repeat_pulse,
   output logic [2*NUM_PLAYERS-1:0]               last_dir,
   output logic [NUM_PLAYERS-1:0]                 last_dir_valid,
   output logic                                   rollover_err
);

   localparam int NK      = NUM_PLAYERS * KEYS_PER_PLAYER;
   localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
   localparam int CW      = $clog2(RPT_MAX + 1);

   logic [NK-1:0]       present;
   logic                rollover;
   logic                accept;
   logic [NUM_DIRS-1:0] dir_press [NUM_PLAYERS];
   logic [NUM_DIRS-1:0] dir_rel   [NUM_PLAYERS];
   logic [NUM_DIRS-1:0] dir_new   [NUM_PLAYERS];
   key_state_t          ld_state  [NUM_PLAYERS];
   logic [1:0]          ld_q      [NUM_PLAYERS];

   // Decode report slots into per-key presence; flag ErrorRollOver
   always_comb begin
      present  = '0;
      rollover = 1'b0;
      for (int s = 0; s < NUM_SLOTS; s++) begin
         if (keycode[8*s +: 8] == KC_ERR_ROLLOVER) rollover = 1'b1;
         for (int p = 0; p < NUM_PLAYERS; p++) begin
            for (int k = 0; k < KEYS_PER_PLAYER; k++) begin
               if (keycode[8*s +: 8] != KC_NONE && keycode[8*s +: 8] == map_code(p, k))
                  present[p*KEYS_PER_PLAYER + k] = 1'b1;
            end
         end
      end
   end

   assign accept = keycode_valid & ~rollover;

   // Held state, edge pulses and the sticky rollover flag
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         held          <= '0;
         press         <= '0;
         release_pulse <= '0;
         rollover_err  <= 1'b0;
      end else begin
         press         <= '0;
         release_pulse <= '0;
         if (keycode_valid && rollover) rollover_err <= 1'b1;
         if (accept) begin
            held          <= present;
            press         <= present & ~held;
            release_pulse <= held & ~present;
         end
      end
   end

   // One repeat timer per key; an ErrorRollOver report leaves them running
   for (genvar i = 0; i < NK; i++) begin : g_timer
      key_repeat_timer #(
         .REPEAT_DELAY (REPEAT_DELAY),
         .REPEAT_PERIOD(REPEAT_PERIOD),
         .CW           (CW)
      ) u_timer (
         .Clk         (Clk),
         .Reset       (Reset),
         .load        (accept & present[i] & ~held[i]),
         .clear       (accept & held[i] & ~present[i]),
         .held        (held[i]),
         .repeat_pulse(repeat_pulse[i])
      );
   end

   for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_dir
      assign dir_new[p]          = present[p*KEYS_PER_PLAYER +: NUM_DIRS];
      assign dir_press[p]        = present[p*KEYS_PER_PLAYER +: NUM_DIRS] & ~held[p*KEYS_PER_PLAYER +: NUM_DIRS];
      assign dir_rel[p]          = held[p*KEYS_PER_PLAYER +: NUM_DIRS] & ~present[p*KEYS_PER_PLAYER +: NUM_DIRS];
      assign last_dir[2*p +: 2]  = ld_q[p];
      assign last_dir_valid[p]   = (ld_state[p] == KS_DIR);
   end

   // Last-direction FSM per player; a new press outranks a fallback on release
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         for (int p = 0; p < NUM_PLAYERS; p++) begin
            ld_state[p] <= KS_NONE;
            ld_q[p]     <= 2'd0;
         end
      end else if (accept) begin
         for (int p = 0; p < NUM_PLAYERS; p++) begin
            if (|dir_press[p]) begin
               ld_state[p] <= KS_DIR;
               ld_q[p]     <= lowest_dir(dir_press[p]);
            end else if (ld_state[p] == KS_DIR && dir_rel[p][ld_q[p]]) begin
               if (|dir_new[p]) begin
                  ld_q[p] <= lowest_dir(dir_new[p]);
               end else begin
                  ld_state[p] <= KS_NONE;
                  ld_q[p]     <= 2'd0;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_keycode_router.sv
// Self-checking bench for keycode_router: directed scenarios plus a random
// report stream, compared against a behavioural model of held keys, press
// timestamps and last-direction rules.
module tb_keycode_router;

   localparam int RD = 24;
   localparam int RP = 8;

   logic        Clk = 1'b0;
   logic        Reset = 1'b1;
   logic [31:0] keycode = '0;
   logic        keycode_valid = 1'b0;
   logic [9:0]  held, press, release_pulse, repeat_pulse;
   logic [3:0]  last_dir;
   logic [1:0]  last_dir_valid;
   logic        rollover_err;

   int checks = 0;
   int failures = 0;

   keycode_router #(
      .NUM_SLOTS(4), .NUM_PLAYERS(2), .KEYS_PER_PLAYER(5),
      .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
   ) dut (
      .Clk(Clk), .Reset(Reset), .keycode(keycode), .keycode_valid(keycode_valid),
      .held(held), .press(press), .release_pulse(release_pulse),
      .repeat_pulse(repeat_pulse), .last_dir(last_dir),
      .last_dir_valid(last_dir_valid), .rollover_err(rollover_err)
   );

   always #5 Clk = ~Clk;

   // ---------------- reference model ----------------
   logic [7:0] kmap [10] = '{8'h1a, 8'h16, 8'h04, 8'h07, 8'h2c,
                             8'h52, 8'h51, 8'h50, 8'h4f, 8'h28};
   logic [9:0] m_held, m_press, m_rel, m_rpt;
   int         m_ld [2];
   logic [1:0] m_ldv;
   logic       m_err;
   int         press_cyc [10];
   int         cyc;

   function automatic logic [31:0] rpt(input logic [7:0] a, input logic [7:0] b,
                                       input logic [7:0] c, input logic [7:0] d);
      return {d, c, b, a};
   endfunction

   function automatic logic [9:0] m_decode(input logic [31:0] kc);
      logic [9:0] r;
      r = '0;
      for (int i = 0; i < 10; i++)
         for (int s = 0; s < 4; s++)
            if (kc[8*s +: 8] != 8'h00 && kc[8*s +: 8] == kmap[i]) r[i] = 1'b1;
      return r;
   endfunction

   function automatic int low_idx(input logic [3:0] x);
      for (int i = 0; i < 4; i++) if (x[i]) return i;
      return 0;
   endfunction

   function automatic logic [46:0] exp_vec();
      return {m_held, m_press, m_rel, m_rpt, 2'(m_ld[1]), 2'(m_ld[0]), m_ldv, m_err};
   endfunction

   function automatic logic [46:0] dut_vec();
      return {held, press, release_pulse, repeat_pulse, last_dir, last_dir_valid, rollover_err};
   endfunction

   task automatic model_reset();
      m_held = '0; m_press = '0; m_rel = '0; m_rpt = '0;
      m_ld[0] = 0; m_ld[1] = 0; m_ldv = '0; m_err = 1'b0; cyc = 0;
      for (int k = 0; k < 10; k++) press_cyc[k] = 0;
   endtask

   task automatic model_step(input bit v, input logic [31:0] kc);
      logic [9:0] nk;
      logic [3:0] pd, nd, rdm;
      bit roll;
      int d;
      roll = 1'b0;
      for (int s = 0; s < 4; s++) if (kc[8*s +: 8] == 8'h01) roll = 1'b1;
      cyc++;
      if (v && roll) m_err = 1'b1;
      nk = (v && !roll) ? m_decode(kc) : m_held;
      m_press = nk & ~m_held;
      m_rel   = m_held & ~nk;
      for (int k = 0; k < 10; k++) begin
         if (m_press[k]) press_cyc[k] = cyc;
         d = cyc - press_cyc[k];
         m_rpt[k] = m_held[k] && nk[k] && d >= RD && ((d - RD) % RP) == 0;
      end
      for (int p = 0; p < 2; p++) begin
         pd  = m_press[p*5 +: 4];
         nd  = nk[p*5 +: 4];
         rdm = m_rel[p*5 +: 4];
         if (pd != 0) begin
            m_ldv[p] = 1'b1; m_ld[p] = low_idx(pd);
         end else if (m_ldv[p] && rdm[m_ld[p]]) begin
            if (nd != 0) m_ld[p] = low_idx(nd);
            else begin m_ldv[p] = 1'b0; m_ld[p] = 0; end
         end
      end
      m_held = nk;
   endtask

   // Drive one cycle of input, then advance the model past the edge
   task automatic cycle(input bit v, input logic [31:0] kc);
      keycode = kc;
      keycode_valid = v;
      @(posedge Clk);
      #1;
      keycode_valid = 1'b0;
      keycode = '0;
      model_step(v, kc);
   endtask

   function automatic logic [7:0] rand_code();
      int r;
      r = $urandom_range(0, 31);
      if (r < 8) return 8'h00;
      else if (r < 28) return kmap[$urandom_range(0, 9)];
      else if (r < 31) return 8'($urandom_range(2, 255));
      return 8'h01;
   endfunction

   // ---------------- scenarios ----------------
   task automatic test_reset();
      Reset = 1'b1;
      model_reset();
      repeat (2) @(posedge Clk);
      #1;
      checks++;
      if (dut_vec() !== 47'd0) begin
         failures++;
         $display("FAIL reset_state actual=%h expected=%h", dut_vec(), 47'd0);
      end
      Reset = 1'b0;
   endtask

   task automatic test_press_repeat();
      int pulses;
      cycle(1, rpt(8'h1a, 8'h00, 8'h00, 8'h00));
      checks++;
      if (held[0] !== 1'b1 || press[0] !== 1'b1 || last_dir[1:0] !== 2'd0 || last_dir_valid[0] !== 1'b1) begin
         failures++;
         $display("FAIL first_press held=%b press=%b ld=%0d ldv=%b required held0=1 press0=1 ld=0 ldv0=1",
                  held, press, last_dir[1:0], last_dir_valid);
      end
      pulses = 0;
      for (int i = 1; i <= 45; i++) begin
         cycle(0, '0);
         if (repeat_pulse[0] === 1'b1) pulses++;
         checks++;
         if (repeat_pulse[0] !== ((i >= RD) && ((i - RD) % RP == 0)) || press[0] !== 1'b0) begin
            failures++;
            $display("FAIL repeat_timing cycle=%0d repeat=%b press=%b", i, repeat_pulse[0], press[0]);
         end
         checks++;
         if (dut_vec() !== exp_vec()) begin
            failures++;
            $display("FAIL hold_model actual=%h expected=%h", dut_vec(), exp_vec());
         end
      end
      checks++;
      if (pulses != 3) begin
         failures++;
         $display("FAIL repeat_count actual=%0d expected=3", pulses);
      end
      cycle(1, rpt(8'h00, 8'h00, 8'h00, 8'h00));
      checks++;
      if (release_pulse[0] !== 1'b1 || repeat_pulse[0] !== 1'b0 || last_dir_valid[0] !== 1'b0 || held[0] !== 1'b0) begin
         failures++;
         $display("FAIL release rel=%b rpt=%b ldv=%b held=%b", release_pulse, repeat_pulse, last_dir_valid, held);
      end
      for (int i = 0; i < 12; i++) begin
         cycle(0, '0);
         checks++;
         if (repeat_pulse !== 10'd0 || release_pulse !== 10'd0) begin
            failures++;
            $display("FAIL after_release rpt=%b rel=%b expected 0", repeat_pulse, release_pulse);
         end
      end
   endtask

   task automatic test_diagonal();
      cycle(1, rpt(8'h04, 8'h1a, 8'h52, 8'h00));
      checks++;
      if (held !== 10'b00001_00101 || last_dir !== 4'b0000 || last_dir_valid !== 2'b11) begin
         failures++;
         $display("FAIL diag_press held=%b ld=%b ldv=%b required held=0000100101 ld=0000 ldv=11",
                  held, last_dir, last_dir_valid);
      end
      cycle(1, rpt(8'h04, 8'h52, 8'h00, 8'h00));
      checks++;
      if (release_pulse !== 10'd1 || last_dir !== 4'b0010 || last_dir_valid !== 2'b11) begin
         failures++;
         $display("FAIL diag_fallback rel=%b ld=%b ldv=%b required rel=0000000001 ld=0010 ldv=11",
                  release_pulse, last_dir, last_dir_valid);
      end
      checks++;
      if (dut_vec() !== exp_vec()) begin
         failures++;
         $display("FAIL diag_model actual=%h expected=%h", dut_vec(), exp_vec());
      end
      cycle(1, '0);
   endtask

   task automatic test_rollover();
      cycle(1, rpt(8'h1a, 8'h00, 8'h00, 8'h00));
      cycle(0, '0);
      cycle(1, rpt(8'h01, 8'h01, 8'h01, 8'h01));
      checks++;
      if (held !== 10'd1 || press !== 10'd0 || release_pulse !== 10'd0 || rollover_err !== 1'b1
          || last_dir_valid !== 2'b01) begin
         failures++;
         $display("FAIL rollover held=%b press=%b rel=%b err=%b ldv=%b", held, press, release_pulse,
                  rollover_err, last_dir_valid);
      end
      for (int i = 0; i < 3; i++) cycle(0, '0);
      cycle(1, rpt(8'h00, 8'h00, 8'h00, 8'h00));
      checks++;
      if (held !== 10'd0 || release_pulse !== 10'd1 || rollover_err !== 1'b1) begin
         failures++;
         $display("FAIL rollover_after held=%b rel=%b err=%b required held=0 rel=1 err=1",
                  held, release_pulse, rollover_err);
      end
   endtask

   task automatic test_action_dup();
      cycle(1, rpt(8'h2c, 8'h2c, 8'h28, 8'h00));
      checks++;
      if (press !== 10'h210 || held !== 10'h210 || last_dir_valid !== 2'b00) begin
         failures++;
         $display("FAIL action_dup press=%h held=%h ldv=%b required press=210 held=210 ldv=00",
                  press, held, last_dir_valid);
      end
      cycle(0, '0);
      checks++;
      if (press !== 10'd0) begin
         failures++;
         $display("FAIL action_single_pulse press=%h expected 000", press);
      end
      cycle(1, '0);
   endtask

   task automatic test_back_to_back();
      cycle(1, rpt(8'h1a, 8'h00, 8'h00, 8'h00));
      for (int i = 0; i < 10; i++) cycle(0, '0);
      cycle(1, rpt(8'h00, 8'h00, 8'h00, 8'h00));
      cycle(1, rpt(8'h00, 8'h1a, 8'h00, 8'h00));
      checks++;
      if (press[0] !== 1'b1 || held[0] !== 1'b1) begin
         failures++;
         $display("FAIL re_press press=%b held=%b", press, held);
      end
      for (int i = 1; i <= RD + 2; i++) begin
         cycle(0, '0);
         checks++;
         if (repeat_pulse[0] !== (i == RD) || dut_vec() !== exp_vec()) begin
            failures++;
            $display("FAIL restart_delay cycle=%0d actual=%h expected=%h", i, dut_vec(), exp_vec());
         end
      end
      cycle(1, '0);
   endtask

   task automatic test_random();
      bit v;
      logic [31:0] kc;
      for (int i = 0; i < 1500; i++) begin
         v  = ($urandom_range(0, 15) == 0);
         kc = {rand_code(), rand_code(), rand_code(), rand_code()};
         cycle(v, kc);
         checks++;
         if (dut_vec() !== exp_vec()) begin
            failures++;
            $display("FAIL random cycle=%0d actual=%h expected=%h", i, dut_vec(), exp_vec());
         end
      end
   endtask

   task automatic test_reset_mid_repeat();
      cycle(1, rpt(8'h1a, 8'h00, 8'h00, 8'h00));
      for (int i = 0; i < 15; i++) cycle(0, '0);
      #3;
      Reset = 1'b1;
      #1;
      checks++;
      if (dut_vec() !== 47'd0) begin
         failures++;
         $display("FAIL async_reset actual=%h expected=%h", dut_vec(), 47'd0);
      end
      @(posedge Clk);
      #1;
      Reset = 1'b0;
      model_reset();
      for (int i = 0; i < 30; i++) begin
         cycle(0, '0);
         checks++;
         if (repeat_pulse !== 10'd0 || dut_vec() !== exp_vec()) begin
            failures++;
            $display("FAIL post_reset_idle actual=%h expected=%h", dut_vec(), exp_vec());
         end
      end
      cycle(1, rpt(8'h1a, 8'h00, 8'h00, 8'h00));
      for (int i = 1; i <= RD + 2; i++) begin
         cycle(0, '0);
         checks++;
         if (repeat_pulse[0] !== (i == RD)) begin
            failures++;
            $display("FAIL post_reset_delay cycle=%0d repeat=%b", i, repeat_pulse[0]);
         end
      end
   endtask

   initial begin
      test_reset();
      test_press_repeat();
      test_diagonal();
      test_rollover();
      test_action_dup();
      test_back_to_back();
      test_random();
      test_reset_mid_repeat();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
